// File: rtl/fifo_flagged.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_flagged #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  rd_ok, wr_ok;

    // Status flags look only at the registered count, never at the current requests.
    assign count        = count_q;
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        rd_ok       = rd & ~empty;
        wr_ok       = wr & (~full | rd_ok);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        if (wr_ok && !rd_ok) count_d = count_q + (ADDR_WIDTH + 1)'(1);
        else if (rd_ok && !wr_ok) count_d = count_q - (ADDR_WIDTH + 1)'(1);
        // A new error in the same cycle beats the clear.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr && !wr_ok) overflow_d  = 1'b1;
        if (rd && !rd_ok) underflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) mem_q[wr_ptr_q] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data = empty ? '0 : mem_q[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

            always_comb begin
                r_data_d = r_data_q;
                if (rd_ok) r_data_d = mem_q[rd_ptr_q];
            end

            always_ff @(posedge clk) begin
                if (!reset) r_data_q <= '0;
                else        r_data_q <= r_data_d;
            end

            assign r_data = r_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flagged.sv
// Bench for fifo_flagged: a queue scoreboard tracks the standard-read instance,
// a second FWFT instance covers the zero-latency read port.
module tb_fifo_flagged;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, wr, rd, clr_err;
    logic [15:0] w_data, r_data;
    logic        empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]  count;

    logic        f_reset, f_wr, f_rd, f_clr_err;
    logic [15:0] f_w_data, f_r_data;
    logic        f_empty, f_full, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [3:0]  f_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] sb[$];
    logic [15:0] m_rdata;
    bit          m_ovf, m_unf;

    fifo_flagged #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data), .rd(rd), .r_data(r_data),
        .empty(empty), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
    );

    fifo_flagged #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .reset(f_reset), .wr(f_wr), .w_data(f_w_data), .rd(f_rd), .r_data(f_r_data),
        .empty(f_empty), .full(f_full), .almost_full(f_almost_full), .almost_empty(f_almost_empty),
        .count(f_count), .clr_err(f_clr_err), .overflow(f_overflow), .underflow(f_underflow)
    );

    // One clock of stimulus on the standard instance, with the scoreboard updated from its own rules.
    task automatic cycle(input bit w, input logic [15:0] d, input bit r, input bit c);
        bit rd_ok, wr_ok;
        wr = w; w_data = d; rd = r; clr_err = c;
        @(posedge clk);
        rd_ok = r && (sb.size() > 0);
        wr_ok = w && ((sb.size() < 8) || rd_ok);
        if (rd_ok) m_rdata = sb.pop_front();
        if (wr_ok) sb.push_back(d);
        if (c) begin m_ovf = 0; m_unf = 0; end
        if (w && !wr_ok) m_ovf = 1;
        if (r && !rd_ok) m_unf = 1;
        #1;
        wr = 0; rd = 0; clr_err = 0;
    endtask

    task automatic f_cycle(input bit w, input logic [15:0] d, input bit r, input bit c);
        f_wr = w; f_w_data = d; f_rd = r; f_clr_err = c;
        @(posedge clk);
        #1;
        f_wr = 0; f_rd = 0; f_clr_err = 0;
    endtask

    task automatic test_reset();
        for (int i = 1; i <= 3; i++) cycle(1, 16'(i), 0, 0);
        reset = 0; wr = 1; w_data = 16'h0004;
        @(posedge clk);
        sb.delete(); m_ovf = 0; m_unf = 0; m_rdata = 16'h0000;
        #1;
        reset = 1; wr = 0;
        n_checks++; if (count !== 4'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("[TB] FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (almost_empty !== 1'b1) $display("[TB] FAIL reset_ae got %b want 1", almost_empty); else n_pass++;
        n_checks++; if ({full, almost_full} !== 2'b00) $display("[TB] FAIL reset_full_af got %b want 00", {full, almost_full}); else n_pass++;
        n_checks++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL reset_err got %b want 00", {overflow, underflow}); else n_pass++;
        n_checks++; if (r_data !== 16'h0000) $display("[TB] FAIL reset_rdata got %h want 0000", r_data); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) begin
            cycle(1, 16'(i), 0, 0);
            n_checks++; if (count !== ((i > 8) ? 4'd8 : 4'(i))) $display("[TB] FAIL fill_count[%0d] got %0d want %0d", i, count, (i > 8) ? 8 : i); else n_pass++;
            n_checks++; if (almost_full !== (i >= 6)) $display("[TB] FAIL fill_af[%0d] got %b want %b", i, almost_full, i >= 6); else n_pass++;
            n_checks++; if (full !== (i >= 8)) $display("[TB] FAIL fill_full[%0d] got %b want %b", i, full, i >= 8); else n_pass++;
            n_checks++; if (overflow !== (i == 9)) $display("[TB] FAIL fill_ovf[%0d] got %b want %b", i, overflow, i == 9); else n_pass++;
        end
        cycle(0, 0, 0, 0);
        n_checks++; if (overflow !== 1'b1) $display("[TB] FAIL ovf_sticky got %b want 1", overflow); else n_pass++;
        cycle(0, 0, 0, 1);
        n_checks++; if (overflow !== 1'b0) $display("[TB] FAIL ovf_clear got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 9; i++) begin
            cycle(0, 0, 1, 0);
            n_checks++; if (r_data !== m_rdata) $display("[TB] FAIL drain_rdata[%0d] got %h want %h", i, r_data, m_rdata); else n_pass++;
            n_checks++; if (r_data !== 16'((i > 8) ? 8 : i)) $display("[TB] FAIL drain_value[%0d] got %h want %h", i, r_data, (i > 8) ? 8 : i); else n_pass++;
            n_checks++; if (almost_empty !== ((i > 8 ? 0 : 8 - i) <= 2)) $display("[TB] FAIL drain_ae[%0d] got %b", i, almost_empty); else n_pass++;
            n_checks++; if (underflow !== (i == 9)) $display("[TB] FAIL drain_unf[%0d] got %b want %b", i, underflow, i == 9); else n_pass++;
        end
        n_checks++; if (count !== 4'd0) $display("[TB] FAIL drain_count got %0d want 0", count); else n_pass++;
        cycle(0, 0, 0, 1);
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 8; i++) cycle(1, 16'(16'h10 + i), 0, 0);
        cycle(1, 16'h00AA, 1, 0);
        n_checks++; if (count !== 4'd8) $display("[TB] FAIL simfull_count got %0d want 8", count); else n_pass++;
        n_checks++; if (r_data !== 16'h0011) $display("[TB] FAIL simfull_rdata got %h want 0011", r_data); else n_pass++;
        n_checks++; if (overflow !== m_ovf) $display("[TB] FAIL simfull_ovf got %b want %b", overflow, m_ovf); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, 0);
            n_checks++; if (r_data !== m_rdata) $display("[TB] FAIL simfull_drain[%0d] got %h want %h", i, r_data, m_rdata); else n_pass++;
        end
        n_checks++; if (r_data !== 16'h00AA) $display("[TB] FAIL simfull_last got %h want 00aa", r_data); else n_pass++;
        cycle(1, 16'h00BB, 1, 0);
        n_checks++; if (count !== 4'd1) $display("[TB] FAIL simempty_count got %0d want 1", count); else n_pass++;
        n_checks++; if (underflow !== 1'b1) $display("[TB] FAIL simempty_unf got %b want 1", underflow); else n_pass++;
        n_checks++; if (r_data !== 16'h00AA) $display("[TB] FAIL simempty_hold got %h want 00aa", r_data); else n_pass++;
        cycle(0, 0, 1, 1);
        n_checks++; if (r_data !== 16'h00BB) $display("[TB] FAIL simempty_read got %h want 00bb", r_data); else n_pass++;
        n_checks++; if (underflow !== 1'b0) $display("[TB] FAIL simempty_clr got %b want 0", underflow); else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) cycle(1, 16'(16'h0050 + i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) cycle(1, 16'(16'h0100 + i), 0, 0);
        n_checks++; if (count !== 4'd7) $display("[TB] FAIL wrap_count got %0d want 7", count); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 1, 0);
            n_checks++; if (r_data !== m_rdata) $display("[TB] FAIL wrap_sb[%0d] got %h want %h", i, r_data, m_rdata); else n_pass++;
            n_checks++; if (r_data !== 16'(16'h0100 + i)) $display("[TB] FAIL wrap_value[%0d] got %h want %h", i, r_data, 16'h0100 + i); else n_pass++;
        end
        n_checks++; if (empty !== 1'b1) $display("[TB] FAIL wrap_empty got %b want 1", empty); else n_pass++;
        n_checks++; if ({overflow, underflow} !== 2'b00) $display("[TB] FAIL wrap_err got %b want 00", {overflow, underflow}); else n_pass++;
    endtask

    task automatic test_fwft();
        n_checks++; if (f_r_data !== 16'h0000) $display("[TB] FAIL fwft_reset_rdata got %h want 0000", f_r_data); else n_pass++;
        f_cycle(1, 16'hA5A5, 0, 0);
        n_checks++; if (f_r_data !== 16'hA5A5) $display("[TB] FAIL fwft_show got %h want a5a5", f_r_data); else n_pass++;
        n_checks++; if (f_empty !== 1'b0) $display("[TB] FAIL fwft_nonempty got %b want 0", f_empty); else n_pass++;
        f_cycle(0, 0, 1, 0);
        n_checks++; if (f_r_data !== 16'h0000) $display("[TB] FAIL fwft_pop_rdata got %h want 0000", f_r_data); else n_pass++;
        n_checks++; if (f_empty !== 1'b1) $display("[TB] FAIL fwft_pop_empty got %b want 1", f_empty); else n_pass++;
        n_checks++; if (f_underflow !== 1'b0) $display("[TB] FAIL fwft_no_unf got %b want 0", f_underflow); else n_pass++;
        f_cycle(0, 0, 1, 1);
        n_checks++; if (f_underflow !== 1'b1) $display("[TB] FAIL fwft_set_wins got %b want 1", f_underflow); else n_pass++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 0; wr = 0; rd = 0; clr_err = 0; w_data = '0;
        f_reset = 0; f_wr = 0; f_rd = 0; f_clr_err = 0; f_w_data = '0;
        m_rdata = '0; m_ovf = 0; m_unf = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1; f_reset = 1;
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        test_fwft();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
